// File: rtl/exe_muldiv.sv
// Iterative multiply/divide/accumulate unit for the EXE stage: radix-2 shift-add
// multiplier and restoring divider sharing one 2*WIDTH working register.
module exe_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [2:0]       op_i,
    input  logic             start_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             stallreq_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [2:0]           op_reg, op_next;
    logic [WIDTH-1:0]     a_reg, a_next;
    logic [WIDTH-1:0]     b_reg, b_next;
    logic                 sign_a_reg, sign_a_next;
    logic                 sign_b_reg, sign_b_next;
    logic                 div0_reg, div0_next;
    logic [WIDTH-1:0]     acc_hi_reg, acc_hi_next;
    logic [WIDTH-1:0]     acc_lo_reg, acc_lo_next;
    logic [2*WIDTH-1:0]   work_reg, work_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [WIDTH-1:0]     hi_reg, hi_next;
    logic [WIDTH-1:0]     lo_reg, lo_next;

    // Start-time decode of the incoming request
    logic                 start_signed, start_div, start_div0;
    logic [WIDTH-1:0]     opa_mag, opb_mag;

    assign start_signed = ~op_i[0];
    assign start_div    = (op_i[2:1] == 2'b01);
    assign start_div0   = start_div && (opb_i == '0);
    assign opa_mag      = (start_signed && opa_i[WIDTH-1]) ? -opa_i : opa_i;
    assign opb_mag      = (start_signed && opb_i[WIDTH-1]) ? -opb_i : opb_i;

    // Held-op decode
    logic                 op_signed, op_div, op_acc, op_sub, neg_res;

    assign op_signed = ~op_reg[0];
    assign op_div    = (op_reg[2:1] == 2'b01);
    assign op_acc    = op_reg[2];
    assign op_sub    = op_reg[1];
    assign neg_res   = op_signed && (sign_a_reg ^ sign_b_reg);

    // Multiply step: work = {partial high, remaining multiplier bits}
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;

    assign mul_sum  = {1'b0, work_reg[2*WIDTH-1:WIDTH]} + {1'b0, (work_reg[0] ? a_reg : '0)};
    assign mul_step = {mul_sum, work_reg[WIDTH-1:1]};

    // Divide step: work = {remainder, dividend bits turning into quotient bits}.
    // The trial value is below 2*divisor, so the low WIDTH bits of the difference suffice.
    logic [WIDTH:0]       div_top;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_sub;
    logic [2*WIDTH-1:0]   div_step;

    assign div_top  = work_reg[2*WIDTH-1:WIDTH-1];
    assign div_ge   = (div_top >= {1'b0, b_reg});
    assign div_sub  = div_top[WIDTH-1:0] - b_reg;
    assign div_step = div_ge ? {div_sub, work_reg[WIDTH-2:0], 1'b1}
                             : {work_reg[2*WIDTH-2:0], 1'b0};

    // Final sign fix and accumulation
    logic [2*WIDTH-1:0]   prod_s, acc_val, mac_val;
    logic [WIDTH-1:0]     quo_s, rem_s;
    logic [WIDTH-1:0]     res_hi, res_lo;

    assign prod_s  = neg_res ? -work_reg : work_reg;
    assign acc_val = {acc_hi_reg, acc_lo_reg};
    assign mac_val = op_sub ? (acc_val - prod_s) : (acc_val + prod_s);
    assign quo_s   = neg_res ? -work_reg[WIDTH-1:0] : work_reg[WIDTH-1:0];
    assign rem_s   = (op_signed && sign_a_reg) ? -work_reg[2*WIDTH-1:WIDTH]
                                               : work_reg[2*WIDTH-1:WIDTH];

    always_comb begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
        if (div0_reg) begin
            res_hi = a_reg;
            res_lo = '1;
        end else if (op_div) begin
            res_hi = rem_s;
            res_lo = quo_s;
        end else if (op_acc) begin
            res_hi = mac_val[2*WIDTH-1:WIDTH];
            res_lo = mac_val[WIDTH-1:0];
        end
    end

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        sign_a_next = sign_a_reg;
        sign_b_next = sign_b_reg;
        div0_next   = div0_reg;
        acc_hi_next = acc_hi_reg;
        acc_lo_next = acc_lo_reg;
        work_next   = work_reg;
        cnt_next    = cnt_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;

        case (state_reg)
            IDLE: begin
                if (start_i && !annul_i) begin
                    op_next     = op_i;
                    sign_a_next = start_signed & opa_i[WIDTH-1];
                    sign_b_next = start_signed & opb_i[WIDTH-1];
                    // A zero divisor skips the iterations and returns the raw dividend
                    a_next      = start_div0 ? opa_i : opa_mag;
                    b_next      = opb_mag;
                    div0_next   = start_div0;
                    acc_hi_next = hi_i;
                    acc_lo_next = lo_i;
                    cnt_next    = '0;
                    work_next   = start_div ? {{WIDTH{1'b0}}, opa_mag}
                                            : {{WIDTH{1'b0}}, opb_mag};
                    state_next  = start_div0 ? FIX : RUN;
                end
            end
            RUN: begin
                if (annul_i) begin
                    state_next = IDLE;
                end else begin
                    work_next = op_div ? div_step : mul_step;
                    cnt_next  = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_ITER) begin
                        state_next = FIX;
                    end
                end
            end
            FIX: begin
                if (annul_i) begin
                    state_next = IDLE;
                end else begin
                    hi_next    = res_hi;
                    lo_next    = res_lo;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            div0_reg   <= 1'b0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            work_reg   <= '0;
            cnt_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            sign_a_reg <= sign_a_next;
            sign_b_reg <= sign_b_next;
            div0_reg   <= div0_next;
            acc_hi_reg <= acc_hi_next;
            acc_lo_reg <= acc_lo_next;
            work_reg   <= work_next;
            cnt_reg    <= cnt_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
        end
    end

    assign hi_o       = hi_reg;
    assign lo_o       = lo_reg;
    assign done_o     = (state_reg == DONE);
    assign busy_o     = (state_reg != IDLE);
    // Low in DONE so the stalled instruction advances with the result
    assign stallreq_o = resetn & (((state_reg == IDLE) & start_i & ~annul_i)
                                  | (state_reg == RUN) | (state_reg == FIX));

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv: a WIDTH=32 and a WIDTH=8 instance checked
// against hand-computed HI/LO values, latencies, annul and reset behaviour.
module tb_exe_muldiv;

    localparam logic [2:0] MULT  = 3'b000, MULTU = 3'b001, DIV  = 3'b010, DIVU  = 3'b011;
    localparam logic [2:0] MADD  = 3'b100, MADDU = 3'b101, MSUB = 3'b110, MSUBU = 3'b111;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  op;
    logic        annul;
    logic        start32, start8;
    logic [31:0] opa32, opb32, hi_in32, lo_in32, hi32, lo32;
    logic        done32, busy32, stall32;
    logic [7:0]  opa8, opb8, hi_in8, lo_in8, hi8, lo8;
    logic        done8, busy8, stall8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exe_muldiv #(.WIDTH(32)) dut32 (
        .clk(clk), .resetn(resetn), .op_i(op), .start_i(start32), .annul_i(annul),
        .opa_i(opa32), .opb_i(opb32), .hi_i(hi_in32), .lo_i(lo_in32),
        .hi_o(hi32), .lo_o(lo32), .done_o(done32), .busy_o(busy32), .stallreq_o(stall32)
    );

    exe_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .resetn(resetn), .op_i(op), .start_i(start8), .annul_i(annul),
        .opa_i(opa8), .opb_i(opb8), .hi_i(hi_in8), .lo_i(lo_in8),
        .hi_o(hi8), .lo_o(lo8), .done_o(done8), .busy_o(busy8), .stallreq_o(stall8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete operation; lat counts edges after the start-accept edge until done_o
    task automatic run_op(input string tag, input int w, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l,
                          input logic [31:0] ehi, input logic [31:0] elo, input int lat);
        int   n;
        logic stall_ok;
        @(negedge clk);
        op    = o;
        annul = 1'b0;
        if (w == 8) begin
            opa8 = a[7:0]; opb8 = b[7:0]; hi_in8 = h[7:0]; lo_in8 = l[7:0]; start8 = 1'b1;
        end else begin
            opa32 = a; opb32 = b; hi_in32 = h; lo_in32 = l; start32 = 1'b1;
        end
        #1;
        chk({tag, ".stall_req"}, 64'((w == 8) ? stall8 : stall32), 64'd1);
        @(posedge clk);
        @(negedge clk);
        start8  = 1'b0;
        start32 = 1'b0;
        // Accumulator inputs must have been captured at the accept edge
        hi_in32 = ~h; lo_in32 = ~l; hi_in8 = ~h[7:0]; lo_in8 = ~l[7:0];
        n = 0;
        stall_ok = 1'b1;
        while (!((w == 8) ? done8 : done32) && n < 200) begin
            if (!((w == 8) ? stall8 : stall32) || !((w == 8) ? busy8 : busy32)) stall_ok = 1'b0;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        $display("%s: op=%0d a=%0h b=%0h -> hi=%0h lo=%0h after %0d edges", tag, o, a, b,
                 (w == 8) ? {24'd0, hi8} : hi32, (w == 8) ? {24'd0, lo8} : lo32, n);
        chk({tag, ".latency"}, 64'(n), 64'(lat));
        chk({tag, ".stall_busy_run"}, 64'(stall_ok), 64'd1);
        chk({tag, ".hi"}, 64'((w == 8) ? {24'd0, hi8} : hi32), 64'(ehi));
        chk({tag, ".lo"}, 64'((w == 8) ? {24'd0, lo8} : lo32), 64'(elo));
        chk({tag, ".stall_done"}, 64'((w == 8) ? stall8 : stall32), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".done_busy_after"}, 64'((w == 8) ? {done8, busy8} : {done32, busy32}), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; op = MULT; annul = 1'b0; start32 = 1'b0; start8 = 1'b0;
        opa32 = '0; opb32 = '0; hi_in32 = '0; lo_in32 = '0;
        opa8 = '0; opb8 = '0; hi_in8 = '0; lo_in8 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.hilo32", {hi32, lo32}, 64'd0);
        chk("reset.flags32", 64'({done32, busy32, stall32}), 64'd0);
        chk("reset.flags8", 64'({hi8, lo8, done8, busy8, stall8}), 64'd0);
        resetn = 1'b1;

        run_op("mult_neg",   32, MULT,  32'hFFFFFFFE, 32'd3,        0, 0,            32'hFFFFFFFF, 32'hFFFFFFFA, 33);
        run_op("multu_max",  32, MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0,            32'hFFFFFFFE, 32'h00000001, 33);
        run_op("divu_100_7", 32, DIVU,  32'd100,      32'd7,        0, 0,            32'd2,        32'd14,       33);
        run_op("div_m7_2",   32, DIV,   32'hFFFFFFF9, 32'd2,        0, 0,            32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        run_op("div_7_m2",   32, DIV,   32'd7,        32'hFFFFFFFE, 0, 0,            32'd1,        32'hFFFFFFFD, 33);
        run_op("div_ovf",    32, DIV,   32'h80000000, 32'hFFFFFFFF, 0, 0,            32'd0,        32'h80000000, 33);
        run_op("divu_by0",   32, DIVU,  32'd5,        32'd0,        0, 0,            32'd5,        32'hFFFFFFFF, 1);
        run_op("div_by0",    32, DIV,   32'hFFFFFFF9, 32'd0,        0, 0,            32'hFFFFFFF9, 32'hFFFFFFFF, 1);
        run_op("maddu_cy",   32, MADDU, 32'd1,        32'd1,        0, 32'hFFFFFFFF, 32'd1,        32'd0,        33);
        run_op("msub_1",     32, MSUB,  32'd1,        32'd1,        0, 0,            32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        run_op("madd_neg",   32, MADD,  32'hFFFFFFFE, 32'd3,        0, 32'd10,       32'd0,        32'd4,        33);
        run_op("msubu",      32, MSUBU, 32'd7,        32'd5,        0, 32'd100,      32'd0,        32'd65,       33);
        run_op("w8_multu",   8,  MULTU, 32'hFF,       32'hFF,       0, 0,            32'hFE,       32'h01,       9);
        run_op("w8_mult",    8,  MULT,  32'h80,       32'hFF,       0, 0,            32'h00,       32'h80,       9);

        // Annul a DIV in flight: prior result (msubu) must survive
        @(negedge clk);
        op = DIV; opa32 = 32'd100; opb32 = 32'd7; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        annul = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul = 1'b0;
        $display("annul: done=%0b busy=%0b hi=%0h lo=%0h", done32, busy32, hi32, lo32);
        chk("annul.done_busy", 64'({done32, busy32}), 64'd0);
        chk("annul.hilo_kept", {hi32, lo32}, {32'd0, 32'd65});
        run_op("after_annul", 32, DIVU, 32'd100, 32'd7, 0, 0, 32'd2, 32'd14, 33);

        // Start together with annul in IDLE is rejected
        @(negedge clk);
        op = MULT; opa32 = 32'd3; opb32 = 32'd3; start32 = 1'b1; annul = 1'b1;
        #1;
        chk("start_annul.stall", 64'(stall32), 64'd0);
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0; annul = 1'b0;
        $display("start+annul: busy=%0b", busy32);
        chk("start_annul.busy", 64'(busy32), 64'd0);

        // Reset in the middle of RUN
        @(negedge clk);
        op = MULTU; opa32 = 32'd9; opb32 = 32'd9; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        $display("mid-run reset: hi=%0h lo=%0h done=%0b busy=%0b stall=%0b",
                 hi32, lo32, done32, busy32, stall32);
        chk("midreset.hilo", {hi32, lo32}, 64'd0);
        chk("midreset.flags", 64'({done32, busy32, stall32}), 64'd0);
        resetn = 1'b1;
        run_op("after_reset", 32, MULTU, 32'd9, 32'd9, 0, 0, 32'd0, 32'd81, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
